enemy_score_ctl: RTL and testbench

- Upstream stage of the enemy-score readout in the game datapath. Replaces the constant currently driven into the enemy-score number drawer.
- Times each duck's flight. If the player does not kill the duck within a fixed time, the duck escapes: the enemy scores a point, and a fly-away phase is signalled to the duck controller and drawer.
- Sits beside duck_game_logic. Consumes hunt_start and duck_killed. Produces enemy_score, seconds_left and the escape/fly-away strobes.

---
 rtl/game_pkg.sv | 12 +
 rtl/enemy_score_ctl_if.sv | 22 ++
 rtl/ms_tick_gen.sv | 31 +++
 rtl/enemy_score_ctl.sv | 140 ++++++++++++++
 tb/tb_enemy_score_ctl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: enemy-score FSM states, score ceiling and
// default timing constants used by top_game and the number drawers.
package game_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, HUNTING, FLY_AWAY} enemy_state_t;

    localparam logic [6:0] ENEMY_SCORE_MAX    = 7'd99;
    localparam int         CLK_HZ_DEF         = 65_000_000;
    localparam int         DUCK_TIMEOUT_S_DEF = 5;
    localparam int         FLYAWAY_MS_DEF     = 500;

endpackage

// File: rtl/enemy_score_ctl_if.sv
// Handshake bundle between duck_game_logic (master) and enemy_score_ctl (slave).
interface enemy_score_ctl_if;

    logic       game_enable;
    logic       hunt_start;
    logic       duck_killed;
    logic [6:0] enemy_score;
    logic [3:0] seconds_left;
    logic       duck_escaped;
    logic       fly_away;

    modport master (
        output game_enable, hunt_start, duck_killed,
        input  enemy_score, seconds_left, duck_escaped, fly_away
    );

    modport slave (
        input  game_enable, hunt_start, duck_killed,
        output enemy_score, seconds_left, duck_escaped, fly_away
    );

endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator: free-running prescaler of CLK_HZ/1000 cycles
// with a synchronous clear so a tick lands exactly one period after clear.
module ms_tick_gen #(
    parameter int CLK_HZ = 65_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int           DIV  = CLK_HZ / 1000;
    localparam int           W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    // Count 0..DIV-1 and wrap; clear restarts the period from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/enemy_score_ctl.sv
// Enemy-score controller: times each duck's flight, scores an escape for the
// enemy on timeout and signals a fly-away phase to the duck controller.
module enemy_score_ctl
    import game_pkg::*;
#(
    parameter int         CLK_HZ         = CLK_HZ_DEF,
    parameter int         DUCK_TIMEOUT_S = DUCK_TIMEOUT_S_DEF,
    parameter int         FLYAWAY_MS     = FLYAWAY_MS_DEF,
    parameter logic [6:0] SCORE_MAX      = ENEMY_SCORE_MAX
) (
    input  logic               clk,
    input  logic               rst,
    enemy_score_ctl_if.slave   sif
);

    localparam logic [9:0] MS_LAST   = 10'd999;
    localparam logic [9:0] FLY_LAST  = 10'(FLYAWAY_MS - 1);
    localparam logic [3:0] SECS_INIT = 4'(DUCK_TIMEOUT_S);

    enemy_state_t r_state;
    logic [6:0]   r_score;
    logic [3:0]   r_secs;
    logic [9:0]   r_ms;
    logic         r_esc;
    logic         r_fly;

    logic         w_tick;
    logic         w_clear;
    logic         w_sec_wrap;
    logic         w_timeout;
    logic [7:0]   w_sum;
    logic [6:0]   w_score_inc;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    assign w_sec_wrap  = w_tick && (r_ms == MS_LAST);
    assign w_timeout   = w_sec_wrap && (r_secs == 4'd1);
    assign w_sum       = {1'b0, r_score} + 8'd1;
    assign w_score_inc = (w_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : w_sum[6:0];

    // Restart the prescaler on every state change so each phase is timed from its entry edge.
    always_comb begin
        w_clear = 1'b0;
        if ((r_state != IDLE) && !sif.game_enable) begin
            w_clear = 1'b1;
        end else begin
            case (r_state)
                IDLE:     w_clear = sif.game_enable;
                ARMED:    w_clear = sif.hunt_start;
                HUNTING:  w_clear = sif.duck_killed || !sif.hunt_start || w_timeout;
                FLY_AWAY: w_clear = w_tick && (r_ms == FLY_LAST);
                default:  w_clear = 1'b1;
            endcase
        end
    end

    // Main FSM with registered outputs; a kill outranks a timeout in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_score <= '0;
            r_secs  <= '0;
            r_ms    <= '0;
            r_esc   <= 1'b0;
            r_fly   <= 1'b0;
        end else begin
            r_esc <= 1'b0;
            if ((r_state != IDLE) && !sif.game_enable) begin
                // Score is kept so the end screen can still show it.
                r_state <= IDLE;
                r_secs  <= '0;
                r_ms    <= '0;
                r_fly   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (sif.game_enable) begin
                            r_state <= ARMED;
                            r_score <= '0;
                        end
                    end
                    ARMED: begin
                        if (sif.hunt_start) begin
                            r_state <= HUNTING;
                            r_secs  <= SECS_INIT;
                            r_ms    <= '0;
                        end
                    end
                    HUNTING: begin
                        if (sif.duck_killed || !sif.hunt_start) begin
                            r_state <= ARMED;
                            r_secs  <= '0;
                            r_ms    <= '0;
                        end else if (w_timeout) begin
                            r_state <= FLY_AWAY;
                            r_secs  <= '0;
                            r_ms    <= '0;
                            r_score <= w_score_inc;
                            r_esc   <= 1'b1;
                            r_fly   <= 1'b1;
                        end else if (w_sec_wrap) begin
                            r_ms    <= '0;
                            r_secs  <= r_secs - 4'd1;
                        end else if (w_tick) begin
                            r_ms    <= r_ms + 10'd1;
                        end
                    end
                    FLY_AWAY: begin
                        if (w_tick) begin
                            if (r_ms == FLY_LAST) begin
                                r_state <= ARMED;
                                r_fly   <= 1'b0;
                                r_ms    <= '0;
                            end else begin
                                r_ms    <= r_ms + 10'd1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_secs  <= '0;
                        r_ms    <= '0;
                        r_fly   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sif.enemy_score  = r_score;
    assign sif.seconds_left = r_secs;
    assign sif.duck_escaped = r_esc;
    assign sif.fly_away     = r_fly;

endmodule

// File: tb/tb_enemy_score_ctl.sv
// Directed bench for enemy_score_ctl: a vector table for the main timing paths
// plus hand sequences for game end, saturation, second countdown and async reset.
module tb_enemy_score_ctl;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    enemy_score_ctl_if mif ();
    enemy_score_ctl_if sif2 ();

    // Main instance: bench timing (10 cycles/ms, 1 s timeout, 5 ms fly-away).
    enemy_score_ctl #(
        .CLK_HZ(10_000), .DUCK_TIMEOUT_S(1), .FLYAWAY_MS(5), .SCORE_MAX(7'd99)
    ) dut (
        .clk(clk), .rst(rst), .sif(mif)
    );

    // Second instance: 1 cycle/ms and a low ceiling so saturation and the
    // seconds countdown are reachable in a few thousand cycles.
    enemy_score_ctl #(
        .CLK_HZ(1000), .DUCK_TIMEOUT_S(2), .FLYAWAY_MS(1), .SCORE_MAX(7'd3)
    ) dut_sat (
        .clk(clk), .rst(rst2), .sif(sif2)
    );

    typedef struct {
        bit ge; bit hs; bit dk; int n;
        int sc; int sl; bit esc; bit fly;
    } vec_t;

    vec_t tbl [17];

    function automatic logic [15:0] pk(input int sc, input int sl, input bit esc, input bit fly);
        return {3'b0, 7'(sc), 4'(sl), esc, fly};
    endfunction

    function automatic logic [15:0] obs_m();
        return {3'b0, mif.enemy_score, mif.seconds_left, mif.duck_escaped, mif.fly_away};
    endfunction

    function automatic logic [15:0] obs_s();
        return {3'b0, sif2.enemy_score, sif2.seconds_left, sif2.duck_escaped, sif2.fly_away};
    endfunction

    function automatic vec_t mk(input bit ge, input bit hs, input bit dk, input int n,
                                input int sc, input int sl, input bit esc, input bit fly);
        vec_t v;
        v.ge = ge; v.hs = hs; v.dk = dk; v.n = n;
        v.sc = sc; v.sl = sl; v.esc = esc; v.fly = fly;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Poll for a duck_escaped pulse on either instance, at most bound cycles.
    task automatic wait_esc(input bit sat, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(posedge clk); #1;
            ok = sat ? sif2.duck_escaped : mif.duck_escaped;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        mif.game_enable  = 1'b0; mif.hunt_start  = 1'b0; mif.duck_killed  = 1'b0;
        sif2.game_enable = 1'b0; sif2.hunt_start = 1'b0; sif2.duck_killed = 1'b0;

        //           ge hs dk  n     sc sl esc fly
        tbl[0]  = mk(0, 0, 0, 1,     0, 0, 0, 0);  // idle
        tbl[1]  = mk(1, 0, 0, 1,     0, 0, 0, 0);  // armed
        tbl[2]  = mk(1, 1, 0, 1,     0, 1, 0, 0);  // hunting entry H
        tbl[3]  = mk(1, 1, 0, 9999,  0, 1, 0, 0);  // H+9999, no escape yet
        tbl[4]  = mk(1, 1, 0, 1,     1, 0, 1, 1);  // H+10000 escape
        tbl[5]  = mk(1, 1, 0, 1,     1, 0, 0, 1);  // pulse is one cycle
        tbl[6]  = mk(1, 1, 0, 20,    1, 0, 0, 1);
        tbl[7]  = mk(1, 1, 1, 1,     1, 0, 0, 1);  // kill ignored in fly-away
        tbl[8]  = mk(1, 1, 0, 27,    1, 0, 0, 1);  // F+49 still flying
        tbl[9]  = mk(1, 1, 0, 1,     1, 0, 0, 0);  // F+50 back to armed
        tbl[10] = mk(1, 1, 0, 1,     1, 1, 0, 0);  // new hunt
        tbl[11] = mk(1, 0, 0, 1,     1, 0, 0, 0);  // hunt_start drop
        tbl[12] = mk(1, 1, 0, 1,     1, 1, 0, 0);  // hunt again
        tbl[13] = mk(1, 1, 0, 9999,  1, 1, 0, 0);
        tbl[14] = mk(1, 1, 1, 1,     1, 0, 0, 0);  // kill on timeout tick
        tbl[15] = mk(1, 1, 0, 1,     1, 1, 0, 0);
        tbl[16] = mk(1, 1, 0, 15,    1, 1, 0, 0);

        #1;
        chk("reset state", obs_m(), pk(0, 0, 0, 0));
        #11;
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            mif.game_enable = tbl[i].ge;
            mif.hunt_start  = tbl[i].hs;
            mif.duck_killed = tbl[i].dk;
            repeat (tbl[i].n) @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), obs_m(),
                pk(tbl[i].sc, tbl[i].sl, tbl[i].esc, tbl[i].fly));
        end

        // Escapes up to score 4, then leave the game during fly-away.
        mif.duck_killed = 1'b0;
        mif.hunt_start  = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            wait_esc(1'b0, 10200, ok);
            chk($sformatf("escape%0d seen", k), {15'b0, ok}, 16'd1);
            chk($sformatf("escape%0d score", k), {9'b0, mif.enemy_score}, 16'(k));
        end
        chk("fly at escape4", {15'b0, mif.fly_away}, 16'd1);
        mif.game_enable = 1'b0;
        @(posedge clk); #1;
        chk("game end", obs_m(), pk(4, 0, 0, 0));
        repeat (60) @(posedge clk); #1;
        chk("idle hold score", obs_m(), pk(4, 0, 0, 0));
        mif.game_enable = 1'b1;
        mif.hunt_start  = 1'b0;
        @(posedge clk); #1;
        chk("re-enable clears score", obs_m(), pk(0, 0, 0, 0));

        // Second instance: countdown, saturation, async reset.
        rst2 = 1'b0;
        sif2.game_enable = 1'b1;
        @(posedge clk); #1;
        chk("sat armed", obs_s(), pk(0, 0, 0, 0));
        sif2.hunt_start = 1'b1;
        @(posedge clk); #1;
        chk("sat hunt entry", obs_s(), pk(0, 2, 0, 0));
        repeat (999) @(posedge clk); #1;
        chk("sat before sec wrap", obs_s(), pk(0, 2, 0, 0));
        @(posedge clk); #1;
        chk("sat sec decrement", obs_s(), pk(0, 1, 0, 0));
        repeat (999) @(posedge clk); #1;
        chk("sat before timeout", obs_s(), pk(0, 1, 0, 0));
        @(posedge clk); #1;
        chk("sat escape1", obs_s(), pk(1, 0, 1, 1));
        @(posedge clk); #1;
        chk("sat fly end", obs_s(), pk(1, 0, 0, 0));
        @(posedge clk); #1;
        chk("sat rehunt", obs_s(), pk(1, 2, 0, 0));
        for (int k = 2; k <= 4; k++) begin
            wait_esc(1'b1, 2100, ok);
            chk($sformatf("sat escape%0d seen", k), {15'b0, ok}, 16'd1);
            chk($sformatf("sat escape%0d score", k), {9'b0, sif2.enemy_score},
                16'((k > 3) ? 3 : k));
        end
        repeat (3) @(posedge clk); #1;
        chk("sat hunting at max", obs_s(), pk(3, 2, 0, 0));
        #2 rst2 = 1'b1;
        #1;
        chk("async reset", obs_s(), pk(0, 0, 0, 0));
        @(posedge clk); #1;
        rst2 = 1'b0;
        @(posedge clk); #1;
        chk("after reset armed", obs_s(), pk(0, 0, 0, 0));
        @(posedge clk); #1;
        chk("after reset hunting", obs_s(), pk(0, 2, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
